debounce_up_down: RTL and testbench
===================================

Name: debounce_up_down

Overview:
Front-end for the 4-bit up/down counter. Conditions two raw push-buttons (up, down) into clean single-cycle step commands, which drive the counter's up/down inputs.
- Per-button synchronizer and debounce filter.
- Mutual-exclusion arbitration between the two buttons.
- Auto-repeat while a button is held.
- Debounced levels exported for LEDs.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms @ 50 MHz); min 2
HOLD_CYCLES, 25000000, cycles after the first pulse before auto-repeat starts (0.5 s); min 2
REPEAT_CYCLES, 5000000, cycles between auto-repeat pulses (0.1 s); min 2

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
btn_up  input  1  raw up button, active-high, asynchronous/bouncy
btn_down  input  1  raw down button, active-high, asynchronous/bouncy
enable  input  1  1 = pulses allowed; 0 = suppress and lock
up  output  1  one-cycle step-up pulse (registered)
down  output  1  one-cycle step-down pulse (registered)
up_level  output  1  debounced up level (registered)
down_level  output  1  debounced down level (registered)

Behaviour:
Reset (rst=0 at posedge):
- Sync FFs, debounced levels, debounce counters, hold/repeat timer = 0.
- FSM = IDLE.
- All outputs = 0.
- Reset mid-hold or mid-bounce discards all progress.

Synchronizer: 2-FF chain per button.

Debounce (per button, independent):
- Counter clears whenever sync output equals the debounced level.
- Otherwise it increments.
- When it reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the debounced level flips and the counter clears.
- Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Counter width is $clog2(DEBOUNCE_CYCLES).

Latency: raw edge (first posedge sampling the new value = edge k) -> level flip at edge k+DEBOUNCE_CYCLES+1 -> first pulse at edge k+DEBOUNCE_CYCLES+2.

Pulse rules:
- up and down are never high in the same cycle.
- Each pulse is exactly 1 cycle wide.

FSM (single, shared; dir register records the active button):
- IDLE:
  - enable=0 or both levels high -> LOCK.
  - Exactly one level high -> pulse that direction, latch dir, timer=0 -> HOLD.
  - Else stay.
- HOLD:
  - dir level low -> IDLE (no pulse).
  - Other level high or enable=0 -> LOCK.
  - Else timer++; at timer==HOLD_CYCLES-1 -> pulse dir, timer=0 -> REPEAT.
- REPEAT: same exit conditions as HOLD; at timer==REPEAT_CYCLES-1 -> pulse dir, timer=0, stay.
- LOCK:
  - No pulses.
  - Exit to IDLE only when both levels are low and enable=1.
  - Releasing one button while the other is still held never generates a pulse.

Timer width: $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).

Boundary cases:
- Simultaneous debounced press of both buttons -> LOCK, zero pulses.
- Release of the active button on the same cycle a timer expires -> release wins, no pulse.
- enable falling on a pulse cycle -> that pulse is suppressed.
- up_level and down_level track the debounced levels regardless of FSM state and enable.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8):
1. Reset: hold rst=0 for 3 cycles with btn_up=1 -> all outputs 0 throughout. Release rst -> up pulses exactly once, at edge 6 after the first sampling edge, then up_level stays 1.
2. Bounce: btn_up toggles 1,0,1,0 each cycle, then holds 1 -> no pulse during toggling; one up pulse 6 edges after the final rising sample; btn_up released after 10 cycles -> no further pulse.
3. Auto-repeat: hold btn_down for 60 cycles -> down pulses at t0, t0+20, t0+28, t0+36, t0+44, t0+52 (6 total); up never asserted.
4. Both buttons: press btn_up and btn_down in the same cycle for 30 cycles -> zero pulses. Release btn_down, keep btn_up -> still zero pulses (LOCK). Release both, re-press btn_up -> one up pulse.
5. Cross-press: hold btn_up (first pulse issued), press btn_down 10 cycles later -> no down pulse, no repeat up pulse. Release both -> FSM back in IDLE, next down press gives 1 pulse.
6. Enable/reset mid-hold: during REPEAT drop enable for 5 cycles -> no pulses, and none after enable returns while the button is still held. Separately, assert rst=0 mid-HOLD -> outputs 0 next edge; first pulse after rst release requires a fresh debounce interval.

Source files
------------

// File: rtl/debounce_up_down.sv
`default_nettype none
// ============================================================================
// Module   : debounce_up_down
// Purpose  : Two-button front end for an up/down counter. Each raw button is
//            synchronised and debounced. A shared arbiter FSM then turns the
//            debounced levels into single-cycle up/down step pulses, with
//            auto-repeat while a button is held.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_up_down #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst,         // synchronous, active-low
  input  logic btn_up,
  input  logic btn_down,
  input  logic enable,
  output logic up,
  output logic down,
  output logic up_level,
  output logic down_level
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = $clog2(TMAX);

  localparam logic [DW-1:0] C_DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] C_HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] C_REP_LAST  = TW'(REPEAT_CYCLES - 1);

  // Bit 0 is the up button, bit 1 is the down button.
  logic [1:0] w_raw;
  logic [1:0] w_level;

  assign w_raw = {btn_down, btn_up};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic [DW-1:0] r_cnt;

    // Two-flop synchroniser, then a counter that only flips the level once
    // the synchronised input has disagreed with it for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_meta  <= 1'b0;
        r_sync  <= 1'b0;
        r_level <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_meta <= w_raw[i];
        r_sync <= r_meta;
        if (r_sync == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == C_DEB_LAST) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_level[i] = r_level;
  end

  assign up_level   = w_level[0];
  assign down_level = w_level[1];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCK   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic          r_dir;       // 0 = up active, 1 = down active
  logic          w_dir_nx;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nx;
  logic          w_up_nx;
  logic          w_down_nx;
  logic          w_dir_lvl;
  logic          w_oth_lvl;
  logic [TW-1:0] w_tlast;

  assign w_dir_lvl = r_dir ? w_level[1] : w_level[0];
  assign w_oth_lvl = r_dir ? w_level[0] : w_level[1];
  assign w_tlast   = (r_state == ST_HOLD) ? C_HOLD_LAST : C_REP_LAST;

  // Arbiter state register and registered step pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
      r_timer <= '0;
      up      <= 1'b0;
      down    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_dir   <= w_dir_nx;
      r_timer <= w_timer_nx;
      up      <= w_up_nx;
      down    <= w_down_nx;
    end
  end

  // Next-state logic: release beats lock, lock beats a timer expiry, so a
  // pulse is never issued on the cycle the button lets go or enable drops.
  always_comb begin
    w_state_nx = r_state;
    w_dir_nx   = r_dir;
    w_timer_nx = r_timer;
    w_up_nx    = 1'b0;
    w_down_nx  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!enable || (&w_level)) begin
          w_state_nx = ST_LOCK;
        end else if (w_level[0]) begin
          w_up_nx    = 1'b1;
          w_dir_nx   = 1'b0;
          w_timer_nx = '0;
          w_state_nx = ST_HOLD;
        end else if (w_level[1]) begin
          w_down_nx  = 1'b1;
          w_dir_nx   = 1'b1;
          w_timer_nx = '0;
          w_state_nx = ST_HOLD;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!w_dir_lvl) begin
          w_timer_nx = '0;
          w_state_nx = ST_IDLE;
        end else if (w_oth_lvl || !enable) begin
          w_timer_nx = '0;
          w_state_nx = ST_LOCK;
        end else if (r_timer == w_tlast) begin
          w_up_nx    = ~r_dir;
          w_down_nx  = r_dir;
          w_timer_nx = '0;
          w_state_nx = ST_REPEAT;
        end else begin
          w_timer_nx = r_timer + 1'b1;
        end
      end
      ST_LOCK: begin
        if (enable && (w_level == 2'b00)) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_up_down.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_debounce_up_down
// Purpose  : Directed self-checking bench for debounce_up_down with
//            DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_up_down;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic enable = 1'b1;
  logic up, down, up_level, down_level;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int both_hi = 0;
  int up_q[$];
  int dn_q[$];
  int m, m2;

  debounce_up_down #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(20),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .enable(enable),
    .up(up),
    .down(down),
    .up_level(up_level),
    .down_level(down_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n clocks; sample 1 ns after each rising edge and log pulse times.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (up) up_q.push_back(cyc);
      if (down) dn_q.push_back(cyc);
      if (up && down) both_hi++;
    end
  endtask

  function automatic int up_at(input int i);
    return (i < up_q.size()) ? up_q[i] : -1;
  endfunction

  function automatic int dn_at(input int i);
    return (i < dn_q.size()) ? dn_q[i] : -1;
  endfunction

  task automatic clear_log();
    up_q.delete();
    dn_q.delete();
  endtask

  initial begin
    int rep_off[6];
    rep_off[0] = 0;  rep_off[1] = 20; rep_off[2] = 28;
    rep_off[3] = 36; rep_off[4] = 44; rep_off[5] = 52;

    // 1. reset with button held, then first press after release
    btn_up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_outs", int'({up, down, up_level, down_level}), 0);
    end
    rst = 1'b1;
    m = cyc;
    clear_log();
    step(12);
    chk("t1_up_n", up_q.size(), 1);
    chk("t1_up_at", up_at(0) - m, 7);
    chk("t1_up_lvl", int'(up_level), 1);
    btn_up = 1'b0;
    step(12);
    chk("t1_rel_n", up_q.size(), 1);
    chk("t1_up_lvl0", int'(up_level), 0);

    // 2. bouncing press
    clear_log();
    btn_up = 1'b1; step(1);
    btn_up = 1'b0; step(1);
    btn_up = 1'b1; step(1);
    btn_up = 1'b0; step(1);
    btn_up = 1'b1;
    m = cyc;
    step(10);
    btn_up = 1'b0;
    step(20);
    chk("t2_up_n", up_q.size(), 1);
    chk("t2_up_at", up_at(0) - m, 7);

    // 3. auto-repeat, release coincides with the next timer expiry
    clear_log();
    btn_down = 1'b1;
    m = cyc;
    step(60);
    btn_down = 1'b0;
    step(12);
    chk("t3_dn_n", dn_q.size(), 6);
    for (int i = 0; i < 6; i++) chk("t3_dn_at", dn_at(i) - m, 7 + rep_off[i]);
    chk("t3_up_n", up_q.size(), 0);

    // 4. both buttons together lock out pulses
    clear_log();
    btn_up = 1'b1;
    btn_down = 1'b1;
    step(30);
    chk("t4_both_pulses", up_q.size() + dn_q.size(), 0);
    chk("t4_levels", int'({up_level, down_level}), 3);
    btn_down = 1'b0;
    step(15);
    chk("t4_one_rel_pulses", up_q.size() + dn_q.size(), 0);
    btn_up = 1'b0;
    step(10);
    m = cyc;
    btn_up = 1'b1;
    step(10);
    btn_up = 1'b0;
    step(12);
    chk("t4_up_n", up_q.size(), 1);
    chk("t4_up_at", up_at(0) - m, 7);
    chk("t4_dn_n", dn_q.size(), 0);

    // 5. cross-press while holding up
    clear_log();
    m = cyc;
    btn_up = 1'b1;
    step(10);
    btn_down = 1'b1;
    step(30);
    btn_up = 1'b0;
    btn_down = 1'b0;
    step(10);
    chk("t5_up_n", up_q.size(), 1);
    chk("t5_up_at", up_at(0) - m, 7);
    chk("t5_dn_n0", dn_q.size(), 0);
    m2 = cyc;
    btn_down = 1'b1;
    step(8);
    btn_down = 1'b0;
    step(12);
    chk("t5_dn_n", dn_q.size(), 1);
    chk("t5_dn_at", dn_at(0) - m2, 7);

    // 6a. enable drops on a repeat pulse cycle
    clear_log();
    m = cyc;
    btn_up = 1'b1;
    step(34);
    enable = 1'b0;
    step(5);
    chk("t6_lvl_no_en", int'(up_level), 1);
    enable = 1'b1;
    step(21);
    btn_up = 1'b0;
    step(12);
    chk("t6_up_n", up_q.size(), 2);
    chk("t6_up_at0", up_at(0) - m, 7);
    chk("t6_up_at1", up_at(1) - m, 27);

    // 6b. reset in the middle of HOLD
    clear_log();
    m = cyc;
    btn_down = 1'b1;
    step(12);
    rst = 1'b0;
    step(1);
    chk("t6_rst_outs", int'({up, down, up_level, down_level}), 0);
    step(1);
    chk("t6_rst_outs2", int'({up, down, up_level, down_level}), 0);
    rst = 1'b1;
    m2 = cyc;
    step(12);
    btn_down = 1'b0;
    step(12);
    chk("t6_dn_n", dn_q.size(), 2);
    chk("t6_dn_at0", dn_at(0) - m, 7);
    chk("t6_dn_at1", dn_at(1) - m2, 7);

    chk("no_both_high", both_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
